// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        REQ  = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10,
        DROP = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// and presents registered out_valid/out_pc/out_instr to the IF/ID register.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   BUS_WIDTH   = 64,
    parameter int                   INSTR_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [BUS_WIDTH-1:0]   redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [BUS_WIDTH-1:0]   imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   out_valid,
    output logic [BUS_WIDTH-1:0]   out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr
);

    localparam logic [BUS_WIDTH-1:0]   PC_STEP    = BUS_WIDTH'(INSTR_BYTES);
    localparam logic [BUS_WIDTH-1:0]   ALIGN_MASK = ~BUS_WIDTH'(INSTR_BYTES - 1);
    localparam logic [INSTR_WIDTH-1:0] NOP        = INSTR_WIDTH'(NOP_INSTR);

    fetch_state_e           state_q,      state_d;
    logic [BUS_WIDTH-1:0]   pc_q,         pc_d;
    logic                   out_valid_q,  out_valid_d;
    logic [BUS_WIDTH-1:0]   out_pc_q,     out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q,  out_instr_d;
    logic [BUS_WIDTH-1:0]   hold_pc_q,    hold_pc_d;
    logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;

    logic                   req_fire;
    logic [BUS_WIDTH-1:0]   target_pc;
    logic [BUS_WIDTH-1:0]   pc_next;

    // The request is gated by rst so nothing is issued while reset is held.
    assign imem_req_valid = (state_q == REQ) && !rst;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign target_pc      = redirect_pc & ALIGN_MASK;
    assign pc_next        = pc_q + PC_STEP;

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        pc_d         = pc_q;
        out_valid_d  = stall ? out_valid_q : 1'b0;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;

        // A redirect flushes the output even under stall.
        if (redirect_valid) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    pc_d    = target_pc;
                    state_d = req_fire ? DROP : REQ;
                end else if (req_fire) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = target_pc;
                    state_d = imem_resp_valid ? REQ : DROP;
                end else if (imem_resp_valid) begin
                    pc_d = pc_next;
                    if (!stall) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = imem_resp_data;
                        state_d     = REQ;
                    end else begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_resp_data;
                        state_d      = HOLD;
                    end
                end
            end

            DROP: begin
                if (redirect_valid) begin
                    pc_d = target_pc;
                end
                if (imem_resp_valid) begin
                    state_d = REQ;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_d         = target_pc;
                    hold_pc_d    = '0;
                    hold_instr_d = NOP;
                    state_d      = REQ;
                end else if (!stall) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = hold_pc_q;
                    out_instr_d = hold_instr_q;
                    state_d     = REQ;
                end
            end

            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= NOP;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge inputs regardless of statement order.
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule
